// File: rtl/byte_bus_reader_pkg.sv
// Shared definitions for the byte-serial bus reader: size encodings, FSM states
// and the per-size last byte index.
package byte_bus_reader_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'd0;
   localparam logic [1:0] SIZE_HALF    = 2'd1;
   localparam logic [1:0] SIZE_WORD    = 2'd2;
   localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   function automatic logic [1:0] last_index(input logic [1:0] sz);
      case (sz)
         SIZE_BYTE: last_index = 2'd0;
         SIZE_HALF: last_index = 2'd1;
         SIZE_WORD: last_index = 2'd3;
         default:   last_index = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/byte_bus_reader_if.sv
// Byte-wide memory read bus: the reader is the master, the memory the slave.
interface byte_bus_reader_if #(parameter int ADDR_WIDTH = 16) ();
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic [7:0]            mem_rdata;
   logic                  mem_ack;

   modport master (output mem_addr, output mem_rd, input mem_rdata, input mem_ack);
   modport slave  (input mem_addr, input mem_rd, output mem_rdata, output mem_ack);
endinterface

// File: rtl/byte_bus_reader_byte_assembler.sv
// 32-bit result register with per-lane byte write and sign fill of the lanes
// above the byte being written, applied in the same edge as that write.
module byte_assembler (
   input  logic        clk,
   input  logic        clear_n,
   input  logic        clr,
   input  logic        we,
   input  logic [1:0]  lane,
   input  logic [7:0]  wdata,
   input  logic        ext,
   output logic [31:0] q
);
   logic [31:0] d_next;

   always_comb begin
      d_next = q;
      if (clr) begin
         d_next = '0;
      end else if (we) begin
         d_next[{lane, 3'b000} +: 8] = wdata;
         if (ext) begin
            for (int i = 0; i < 4; i++) begin
               if (i > int'(lane)) d_next[i*8 +: 8] = {8{wdata[7]}};
            end
         end
      end
   end

   dff #(.WIDTH(32)) u_data (
      .clk     (clk),
      .clear_n (clear_n),
      .d       (d_next),
      .q       (q)
   );
endmodule

// File: rtl/dff.sv
// Register primitive with asynchronous active-low clear.
module dff #(parameter int WIDTH = 8) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) q <= '0;
      else          q <= d;
   end
endmodule

// File: rtl/byte_bus_reader.sv
// Fetches a 1/2/4-byte little-endian value over a byte-wide bus, one byte per
// mem_ack, and assembles it into a 32-bit result with optional sign extension.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | mem_rd held, collecting one byte per ack, wait timer running
// DONE   | one-cycle done pulse, data final
// ERR    | one-cycle error pulse (illegal size or ack timeout)
module byte_bus_reader
   import byte_bus_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   output logic [31:0]           data,
   output logic                  done,
   output logic                  error,
   output logic                  busy,
   byte_bus_reader_if.master     mem
);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_q, rd_d;
   logic [1:0]            idx_q, idx_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [1:0]            size_q, size_d;
   logic                  sext_q, sext_d;
   logic                  asm_clr, asm_we, asm_ext;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         idx_q   <= '0;
         wait_q  <= '0;
         size_q  <= SIZE_BYTE;
         sext_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      size_d  = size_q;
      sext_d  = sext_q;
      asm_clr = 1'b0;
      asm_we  = 1'b0;
      asm_ext = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (size == SIZE_ILLEGAL) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_READ;
                  rd_d    = 1'b1;
                  addr_d  = addr;
                  idx_d   = '0;
                  wait_d  = WAIT_W'(MAX_WAIT - 1);
                  size_d  = size;
                  sext_d  = sign_ext;
                  asm_clr = 1'b1;
               end
            end
         end
         S_READ: begin
            if (mem.mem_ack) begin
               asm_we = 1'b1;
               wait_d = WAIT_W'(MAX_WAIT - 1);
               if (idx_q == last_index(size_q)) begin
                  state_d = S_DONE;
                  rd_d    = 1'b0;
                  asm_ext = sext_q;
               end else begin
                  idx_d  = idx_q + 2'd1;
                  addr_d = addr_q + ADDR_WIDTH'(1);
               end
            end else if (wait_q == '0) begin
               // Timer expired: abandon the access, keep the bytes already read.
               state_d = S_ERR;
               rd_d    = 1'b0;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   byte_assembler u_asm (
      .clk     (clk),
      .clear_n (clear_n),
      .clr     (asm_clr),
      .we      (asm_we),
      .lane    (idx_q),
      .wdata   (mem.mem_rdata),
      .ext     (asm_ext),
      .q       (data)
   );

   assign mem.mem_addr = addr_q;
   assign mem.mem_rd   = rd_q;
   assign done         = (state_q == S_DONE);
   assign error        = (state_q == S_ERR);
   assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_byte_bus_reader.sv
// Directed bench for byte_bus_reader: table of reads against a byte memory
// model with configurable wait states, plus reset-abort and busy-start cases.
module tb_byte_bus_reader;

   typedef struct {
      logic [15:0] addr;
      logic [1:0]  size;
      logic        sext;
      int          wt;
      int          max_acks;
      logic [31:0] bytes;
      logic [31:0] exp_data;
      bit          chk_data;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   logic        clk;
   logic        clear_n;
   logic        start;
   logic [15:0] addr;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] data;
   logic        done;
   logic        error;
   logic        busy;

   byte_bus_reader_if #(.ADDR_WIDTH(16)) mem_if ();

   byte_bus_reader #(.ADDR_WIDTH(16), .MAX_WAIT(15)) dut (
      .clk      (clk),
      .clear_n  (clear_n),
      .start    (start),
      .addr     (addr),
      .size     (size),
      .sign_ext (sign_ext),
      .data     (data),
      .done     (done),
      .error    (error),
      .busy     (busy),
      .mem      (mem_if)
   );

   logic [7:0]  img [0:65535];
   logic [15:0] addr_log [$];
   int          mem_wait;
   int          max_acks;
   int          acks_given;
   int          wcnt;
   int          done_cnt;
   int          err_cnt;
   int          both_cnt;
   bit          rd_seen;
   int          checks;
   int          errors;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model and pulse monitor, both acting on the falling edge.
   initial begin
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 8'h00;
      wcnt = 0;
      forever begin
         @(negedge clk);
         if (done && error) both_cnt++;
         if (done) done_cnt++;
         if (error) err_cnt++;
         if (mem_if.mem_rd) rd_seen = 1'b1;
         if (mem_if.mem_rd && acks_given < max_acks) begin
            if (wcnt >= mem_wait) begin
               mem_if.mem_ack   = 1'b1;
               mem_if.mem_rdata = img[mem_if.mem_addr];
               addr_log.push_back(mem_if.mem_addr);
               acks_given++;
               wcnt = 0;
            end else begin
               mem_if.mem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            mem_if.mem_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      case (sz)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   task automatic run_vec(input vec_t v, input string nm);
      int nb, nacks, lat, d0, e0, mism;
      nb = nbytes(v.size);
      nacks = (v.max_acks < nb) ? v.max_acks : nb;
      for (int i = 0; i < 4; i++) img[16'(v.addr + 16'(i))] = v.bytes[i*8 +: 8];
      mem_wait = v.wt;
      max_acks = v.max_acks;
      acks_given = 0;
      addr_log.delete();
      rd_seen = 1'b0;
      d0 = done_cnt;
      e0 = err_cnt;
      addr = v.addr;
      size = v.size;
      sign_ext = v.sext;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!(done || error) && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, lat, v.exp_lat);
      chk({nm, "_done"}, {31'd0, done}, {31'd0, !v.exp_err});
      chk({nm, "_error"}, {31'd0, error}, {31'd0, v.exp_err});
      if (v.chk_data) chk({nm, "_data"}, data, v.exp_data);
      chk({nm, "_rd_end"}, {31'd0, mem_if.mem_rd}, 32'd0);
      @(negedge clk);
      chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({nm, "_done_pulses"}, done_cnt - d0, v.exp_err ? 0 : 1);
      chk({nm, "_err_pulses"}, err_cnt - e0, v.exp_err ? 1 : 0);
      chk({nm, "_acks"}, addr_log.size(), nacks);
      mism = 0;
      for (int i = 0; i < nacks && i < addr_log.size(); i++)
         if (addr_log[i] !== 16'(v.addr + 16'(i))) mism++;
      chk({nm, "_addr_seq"}, mism, 0);
      if (v.size == 2'd3) chk({nm, "_no_rd"}, {31'd0, rd_seen}, 32'd0);
   endtask

   initial begin
      vec_t vecs [11];
      vec_t vb;
      int   d0, lat;

      vecs[0]  = '{16'h0010, 2'd2, 1'b0, 0, 4, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 5};
      vecs[1]  = '{16'h0020, 2'd1, 1'b1, 0, 4, 32'h00008034, 32'hFFFF8034, 1'b1, 1'b0, 3};
      vecs[2]  = '{16'h0020, 2'd1, 1'b0, 0, 4, 32'h00008034, 32'h00008034, 1'b1, 1'b0, 3};
      vecs[3]  = '{16'hFFFF, 2'd0, 1'b1, 2, 4, 32'h0000009A, 32'hFFFFFF9A, 1'b1, 1'b0, 4};
      vecs[4]  = '{16'hFFFE, 2'd2, 1'b1, 2, 4, 32'hF4332211, 32'hF4332211, 1'b1, 1'b0, 13};
      vecs[5]  = '{16'h0005, 2'd0, 1'b1, 0, 4, 32'h0000007F, 32'h0000007F, 1'b1, 1'b0, 2};
      vecs[6]  = '{16'h0030, 2'd3, 1'b0, 0, 4, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1};
      vecs[7]  = '{16'h0100, 2'd2, 1'b0, 0, 0, 32'hAABBCCEF, 32'h00000000, 1'b1, 1'b1, 16};
      vecs[8]  = '{16'h0100, 2'd2, 1'b0, 0, 1, 32'hAABBCCEF, 32'h000000EF, 1'b1, 1'b1, 17};
      vecs[9]  = '{16'h0200, 2'd1, 1'b1, 1, 4, 32'h0000FF01, 32'hFFFFFF01, 1'b1, 1'b0, 5};
      vecs[10] = '{16'h0300, 2'd0, 1'b0, 0, 4, 32'h00000080, 32'h00000080, 1'b1, 1'b0, 2};

      checks = 0; errors = 0;
      done_cnt = 0; err_cnt = 0; both_cnt = 0;
      mem_wait = 0; max_acks = 4; acks_given = 0; rd_seen = 1'b0;
      clear_n = 1'b0; start = 1'b0; addr = '0; size = '0; sign_ext = 1'b0;

      #3;
      chk("rst_data", data, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_if.mem_addr}, 32'd0);
      chk("rst_mem_rd", {31'd0, mem_if.mem_rd}, 32'd0);
      chk("rst_flags", {29'd0, done, error, busy}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      clear_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset in the middle of a word read, after two bytes have landed.
      img[16'h0040] = 8'hAA; img[16'h0041] = 8'hBB;
      img[16'h0042] = 8'hCC; img[16'h0043] = 8'hDD;
      mem_wait = 0; max_acks = 4; acks_given = 0;
      d0 = done_cnt;
      addr = 16'h0040; size = 2'd2; sign_ext = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_partial", data, 32'h0000BBAA);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      #2 clear_n = 1'b0;
      #1;
      chk("abort_mem_rd", {31'd0, mem_if.mem_rd}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_data", data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      clear_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      vb = '{16'h0050, 2'd0, 1'b0, 0, 4, 32'h000000C3, 32'h000000C3, 1'b1, 1'b0, 2};
      run_vec(vb, "post_abort");

      // A second start while busy must be dropped.
      img[16'h0060] = 8'h01; img[16'h0061] = 8'h02;
      img[16'h0062] = 8'h03; img[16'h0063] = 8'h04;
      mem_wait = 1; max_acks = 4; acks_given = 0;
      addr_log.delete();
      d0 = done_cnt;
      addr = 16'h0060; size = 2'd2; sign_ext = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      addr = 16'h0070; size = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("busy_start_data", data, 32'h04030201);
      for (int i = 0; i < 5; i++) @(negedge clk);
      chk("busy_start_one_done", done_cnt - d0, 1);
      chk("busy_start_idle", {31'd0, busy}, 32'd0);
      chk("busy_start_acks", addr_log.size(), 4);
      chk("busy_start_last_addr", {16'd0, addr_log[addr_log.size()-1]}, 32'h00000063);

      chk("done_error_overlap", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
